// File: rtl/uart_rx_if.sv
// Receive-side handshake bundle: received word, valid/ready pair and overrun pulse.
// master = receiver (drives data/valid/overrun), slave = consuming logic (drives ready).
interface uart_rx_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  ready;
  logic                  overrun;

  modport master (
    output data,
    output valid,
    output overrun,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    input  overrun,
    output ready
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 1 start, DATA_WIDTH data bits LSB first, 1 stop, no parity; valid/ready output.
// Optional UART_RX_FRAME_ERR_EN adds a one-cycle frame_err pulse on a bad stop bit.
module uart_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int BAUD_RATE  = 115200,
  parameter int CLK_FREQ   = 100_000_000
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      uart_in,
`ifdef UART_RX_FRAME_ERR_EN
  output logic      frame_err,
`endif
  uart_rx_if.master rx_if
);

  localparam int PULSE_WIDTH      = CLK_FREQ / BAUD_RATE;
  localparam int HALF_PULSE_WIDTH = PULSE_WIDTH / 2;
  localparam int CCW              = (PULSE_WIDTH > 1) ? $clog2(PULSE_WIDTH) : 1;
  localparam int BCW              = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CCW-1:0] CNT_FULL = CCW'(PULSE_WIDTH - 1);
  localparam logic [CCW-1:0] CNT_HALF = CCW'(HALF_PULSE_WIDTH - 1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_e;

  state_e                state_q, state_d;
  logic [1:0]            sync_q, sync_d;
  logic [CCW-1:0]        clk_cnt_q, clk_cnt_d;
  logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  overrun_q, overrun_d;
`ifdef UART_RX_FRAME_ERR_EN
  logic                  frame_err_q, frame_err_d;
`endif

  logic rx_s;
  logic sample;
  logic word_done;

  assign sync_d = {sync_q[0], uart_in};
  assign rx_s   = sync_q[1];
  assign sample = (clk_cnt_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sync_q      <= 2'b11;
      clk_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
      frame_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
`ifdef UART_RX_FRAME_ERR_EN
      frame_err_q <= frame_err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!rx_s) state_d = S_START;
      S_START: if (sample) state_d = rx_s ? S_IDLE : S_DATA;
      S_DATA:  if (sample && (bit_cnt_q == BIT_LAST)) state_d = S_STOP;
      S_STOP:  if (sample) state_d = rx_s ? S_IDLE : S_BREAK;
      // A held-low line parks here so it cannot retrigger a frame.
      S_BREAK: if (rx_s) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    clk_cnt_d   = clk_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = valid_q;
    overrun_d   = 1'b0;
    word_done   = 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
    frame_err_d = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (!rx_s) clk_cnt_d = CNT_HALF;
      end
      S_START: begin
        if (!sample) begin
          clk_cnt_d = clk_cnt_q - 1'b1;
        end else if (!rx_s) begin
          clk_cnt_d = CNT_FULL;
          bit_cnt_d = '0;
        end
      end
      S_DATA: begin
        if (!sample) begin
          clk_cnt_d = clk_cnt_q - 1'b1;
        end else begin
          shift_d[bit_cnt_q] = rx_s;
          clk_cnt_d          = CNT_FULL;
          if (bit_cnt_q != BIT_LAST) bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (!sample) begin
          clk_cnt_d = clk_cnt_q - 1'b1;
        end else if (rx_s) begin
          word_done = 1'b1;
        end else begin
`ifdef UART_RX_FRAME_ERR_EN
          frame_err_d = 1'b1;
`endif
        end
      end
      default: ;
    endcase

    // A finished word is accepted only if the output slot is free or being freed now.
    if (word_done && (!valid_q || rx_if.ready)) begin
      data_d  = shift_q;
      valid_d = 1'b1;
    end else if (word_done) begin
      overrun_d = 1'b1;
    end else if (valid_q && rx_if.ready) begin
      valid_d = 1'b0;
    end
  end

  assign rx_if.data    = data_q;
  assign rx_if.valid   = valid_q;
  assign rx_if.overrun = overrun_q;
`ifdef UART_RX_FRAME_ERR_EN
  assign frame_err     = frame_err_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: a behavioural line driver pushes expected words,
// a negedge monitor pops and compares on each accepted handshake.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int DW   = 8;
  localparam int CF   = 16;
  localparam int BAUD = 1;
  localparam int PW   = CF / BAUD;

  logic clk = 1'b0;
  logic rst;
  logic uart_in;
`ifdef UART_RX_FRAME_ERR_EN
  logic frame_err;
`endif

  always #5 clk = ~clk;

  uart_rx_if #(.DATA_WIDTH(DW)) rx_if ();

  uart_rx #(
    .DATA_WIDTH(DW),
    .BAUD_RATE (BAUD),
    .CLK_FREQ  (CF)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .uart_in  (uart_in),
`ifdef UART_RX_FRAME_ERR_EN
    .frame_err(frame_err),
`endif
    .rx_if    (rx_if)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int t_fall = 0;
  int first_valid_cyc = -1;
  int ovr_seen  = 0;
  int ovr_exp   = 0;
  int ferr_seen = 0;
  int ferr_exp  = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_word;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (rx_if.overrun === 1'b1) ovr_seen++;
`ifdef UART_RX_FRAME_ERR_EN
      if (frame_err === 1'b1) ferr_seen++;
`endif
      if (rx_if.valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (rx_if.valid === 1'b1 && rx_if.ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_valid: got word 0x%0h, required no word", rx_if.data);
        end else begin
          exp_word = exp_q.pop_front();
          check("rx_data", 32'(rx_if.data), 32'(exp_word));
        end
      end
    end
  end

  task automatic drive_bit(input logic b, input int n);
    @(posedge clk);
    #1 uart_in = b;
    repeat (n - 1) @(posedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference transmitter; a good frame's word is queued before it goes on the line.
  task automatic send_frame(input logic [DW-1:0] d, input bit push, input logic stop_b);
    if (push) exp_q.push_back(d);
    @(posedge clk);
    #1 uart_in = 1'b0;
    t_fall = cyc;
    repeat (PW - 1) @(posedge clk);
    for (int i = 0; i < DW; i++) drive_bit(d[i], PW);
    drive_bit(stop_b, PW);
  endtask

  initial begin
    logic [DW-1:0] rnd;
    rst         = 1'b1;
    uart_in     = 1'b1;
    rx_if.ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_valid", 32'(rx_if.valid), 32'd0);
    check("reset_data", 32'(rx_if.data), 32'd0);
    check("reset_overrun", 32'(rx_if.overrun), 32'd0);
`ifdef UART_RX_FRAME_ERR_EN
    check("reset_frame_err", 32'(frame_err), 32'd0);
`endif
    @(posedge clk);
    #1 rst = 1'b0;
    idle(4);

    // single frame with exact latency from line fall to valid
    first_valid_cyc = -1;
    send_frame(8'hA5, 1'b1, 1'b1);
    idle(4);
    check("a5_latency", 32'(first_valid_cyc - t_fall), 32'd155);
    check("a5_drained", 32'(exp_q.size()), 32'd0);

    // short low glitch must be rejected at the start-bit sample
    drive_bit(1'b0, 5);
    drive_bit(1'b1, 2 * PW);
    check("glitch_no_word", 32'(rx_if.valid), 32'd0);
    send_frame(8'h3C, 1'b1, 1'b1);
    idle(4);
    check("3c_drained", 32'(exp_q.size()), 32'd0);

    // overrun: two frames with ready low, second word dropped
    rx_if.ready = 1'b0;
    send_frame(8'h01, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1);
    ovr_exp++;
    idle(4);
    check("ovr_count", 32'(ovr_seen), 32'(ovr_exp));
    check("ovr_valid_held", 32'(rx_if.valid), 32'd1);
    check("ovr_data_held", 32'(rx_if.data), 32'h01);
    rx_if.ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("valid_drop", 32'(rx_if.valid), 32'd0);
    check("ovr_drained", 32'(exp_q.size()), 32'd0);

    // bad stop bit followed by a long break
    send_frame(8'h55, 1'b0, 1'b0);
    drive_bit(1'b0, 40);
`ifdef UART_RX_FRAME_ERR_EN
    ferr_exp++;
`endif
    drive_bit(1'b1, 2 * PW);
    check("break_no_word", 32'(exp_q.size()), 32'd0);
    check("frame_err_count", 32'(ferr_seen), 32'(ferr_exp));
    send_frame(8'h80, 1'b1, 1'b1);
    idle(4);
    check("80_drained", 32'(exp_q.size()), 32'd0);
    check("80_data", 32'(rx_if.data), 32'h80);

    // reset during data bit 4 of 0xC3
    @(posedge clk);
    #1 uart_in = 1'b0;
    repeat (PW - 1) @(posedge clk);
    for (int i = 0; i < 4; i++) drive_bit(rnd_bit(8'hC3, i), PW);
    drive_bit(1'b0, PW / 2);
    @(posedge clk);
    #1 begin rst = 1'b1; uart_in = 1'b1; end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_valid", 32'(rx_if.valid), 32'd0);
    check("midrst_data", 32'(rx_if.data), 32'd0);
    idle(2 * PW);
    check("midrst_no_word", 32'(rx_if.valid), 32'd0);
    send_frame(8'h5A, 1'b1, 1'b1);
    idle(4);
    check("5a_drained", 32'(exp_q.size()), 32'd0);

    // back-to-back loopback words
    send_frame(8'h00, 1'b1, 1'b1);
    send_frame(8'h7F, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b1);
    idle(4);
    check("loop_drained", 32'(exp_q.size()), 32'd0);

    // random words with random idle gaps
    for (int n = 0; n < 24; n++) begin
      rnd = DW'($urandom_range(0, 255));
      send_frame(rnd, 1'b1, 1'b1);
      idle($urandom_range(0, 3));
    end
    idle(4);
    check("rand_drained", 32'(exp_q.size()), 32'd0);
    check("final_ovr_count", 32'(ovr_seen), 32'(ovr_exp));
    check("final_frame_err_count", 32'(ferr_seen), 32'(ferr_exp));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  function automatic logic rnd_bit(input logic [DW-1:0] d, input int i);
    return d[i];
  endfunction

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver; the downstream counterpart of the team's UART transmitter on the same link.
- Frame format: 1 start bit (0), DATA_WIDTH data bits LSB first, 1 stop bit (1), no parity.
- Deserialises uart_in and presents each good word on a valid/ready output handshake to the consuming logic.
- Detects false starts, bad stop bits and overrun.

Parameters:
DATA_WIDTH, 8, width of received word
BAUD_RATE, 115200, line bit rate
CLK_FREQ, 100_000_000, clk frequency in Hz; PULSE_WIDTH = CLK_FREQ/BAUD_RATE (integer divide), must be >= 4; HALF_PULSE_WIDTH = PULSE_WIDTH/2

Ports:
clk  input  1  clock; all logic on posedge
rst  input  1  synchronous reset, active-high
uart_in  input  1  asynchronous serial line, idle high
data  output  DATA_WIDTH  received word; stable while valid=1
valid  output  1  word available
ready  input  1  consumer accepts word when valid&&ready
overrun  output  1  one-cycle pulse: completed word dropped because previous word unconsumed

Behaviour:
- Interface: one clock (clk); reset rst is synchronous, active-high.
- Reset values: data=0, valid=0, overrun=0, state=IDLE, both synchroniser flops=1, counters=0.
- Input sync: uart_in passes through 2 flops (reset to 1); rx_s is the second flop. All decisions use rx_s.
- State machine. clk_cnt counts down; a "sample" occurs in the cycle clk_cnt==0.
- IDLE:
  - If rx_s==0: clk_cnt<=HALF_PULSE_WIDTH-1, go START.
- START:
  - At sample, rx_s==1: false start, go IDLE, nothing reported.
  - At sample, rx_s==0: clk_cnt<=PULSE_WIDTH-1, bit_cnt<=0, go DATA.
- DATA:
  - At each sample: shift_r[bit_cnt]<=rx_s and clk_cnt<=PULSE_WIDTH-1.
  - When bit_cnt==DATA_WIDTH-1, go STOP; else bit_cnt++.
- STOP:
  - At sample, rx_s==1: word complete, go IDLE.
  - At sample, rx_s==0: framing error, word discarded, go BREAK.
- BREAK: stay until rx_s==1, then go IDLE. A held-low line never produces repeated frames.
- Samples sit mid-bit, nominally. Sample times relative to the rx_s falling edge: start bit at +HALF_PULSE_WIDTH; data bit k at +HALF_PULSE_WIDTH+(k+1)*PULSE_WIDTH.
- Output handshake:
  - On word complete with valid==0, or with valid&&ready in the same cycle: data<=shift_r and valid<=1 on the next edge. Valid is therefore 1 the cycle after the stop sample.
  - On word complete with valid==1 && ready==0: new word dropped, data unchanged, overrun=1 for exactly one cycle.
  - valid&&ready with no completing word: valid<=0 next cycle; data holds its last value.
  - The receiver never stalls the line: reception continues regardless of ready.
- Reset mid-frame: everything returns to reset values the next edge; any partial word is lost; no valid or overrun is generated.
- Widths: bit_cnt is $clog2(DATA_WIDTH) bits. clk_cnt is $clog2(PULSE_WIDTH) bits and must hold PULSE_WIDTH-1.

Optional Feature:
- Macro: UART_RX_FRAME_ERR_EN.
- Defined:
  - Adds output port frame_err (1 bit, reset 0).
  - frame_err pulses 1 cycle, the cycle after a STOP sample with rx_s==0.
  - The word is still discarded and valid is unaffected.
- Undefined:
  - Port absent.
  - Framing errors are silently discarded; BREAK behaviour is identical.

Test Plan:
- Common bench settings: CLK_FREQ=16, BAUD_RATE=1 (PULSE_WIDTH=16), DATA_WIDTH=8, ready held 1 unless stated. Byte timings are in clk cycles.
- Frame 0xA5 at 16 clk/bit -> valid=1 with data=0xA5 for exactly one cycle; valid rises 2+8+9*16+1 cycles (approx.) after the uart_in falling edge; overrun=0.
- Low glitch of 5 cycles on idle line -> START rejects at half-bit; no valid; state back to IDLE; a following 0x3C frame is received correctly.
- Two back-to-back frames 0x01 then 0xFF with ready=0 throughout -> valid=1, data=0x01 held; overrun pulses once at the second stop sample. Then raise ready -> valid drops the next cycle.
- Frame 0x55 with stop bit forced 0, line held low 40 cycles, then high -> no valid; frame_err pulses once (macro on); no further frames until line high. The next 0x80 frame is received correctly.
- Assert rst during data bit 4 of frame 0xC3 -> valid=0, data=0 after reset; the next full frame 0x5A is received as 0x5A.
- Transmitter loopback (TX uart_out -> uart_in, same parameters) sending 0x00, 0x7F, 0xFF -> three valids with matching data, in order.
